lakespec_read_port_ctrl: RTL

//  Egress (read-side) ready/valid controller for one lakespec output port (port_N/_valid/_ready).

---
 rtl/lakespec_pkg.sv | 17 +
 rtl/lakespec_rv_fifo2.sv | 66 ++++++
 rtl/lakespec_read_port_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/lakespec_pkg.sv
// Shared types for the lakespec port controllers (read and write side).
package lakespec_pkg;

    localparam int LS_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ls_state_e;

    typedef struct packed {
        logic [LS_CNT_WIDTH-1:0] num_data;
        logic                    is_static;
    } port_cfg_t;

endpackage

// File: rtl/lakespec_rv_fifo2.sv
// Two-entry ready/valid buffer; push and pop may coincide at any occupancy.
module lakespec_rv_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  do_push, do_pop;

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign head  = mem_q[rd_ptr_q];

    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            mem_d    = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lakespec_read_port_ctrl.sv
// Egress controller: pulls memory read words through a 2-entry buffer onto one output port,
// optionally stopping after cfg_num_data accepted transfers.
//
//   state   | meaning
//   IDLE    | after reset/flush; no fetch, port_valid=0
//   RUN     | fetching and delivering words
//   DONE    | dynamic count reached; parked until flush
module lakespec_read_port_ctrl
    import lakespec_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [CNT_WIDTH-1:0]  cfg_num_data,
    input  logic                  cfg_static,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] port_data,
    output logic                  port_valid,
    input  logic                  port_ready,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    ls_state_e             state_q, state_d;
    logic [CNT_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_WIDTH-1:0]  xfer_count_q, xfer_count_d;
    logic                  done_q, done_d;

    port_cfg_t             cfg;
    logic [CNT_WIDTH-1:0]  num_lim;
    logic                  buf_full, buf_empty;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] buf_head;

    assign cfg     = '{num_data: LS_CNT_WIDTH'(cfg_num_data), is_static: cfg_static};
    assign num_lim = CNT_WIDTH'(cfg.num_data);

    // Fetch gating uses only registered state, so port_ready never reaches mem_ready.
    assign mem_ready  = (state_q == ST_RUN) & ~buf_full &
                        (cfg.is_static | (issue_cnt_q < num_lim));
    assign port_valid = ~buf_empty & (state_q != ST_IDLE);
    assign port_data  = buf_head;
    assign done       = done_q;
    assign xfer_count = xfer_count_q;

    assign push = mem_valid & mem_ready;
    assign pop  = port_valid & port_ready;

    lakespec_rv_fifo2 #(
        .WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .wdata (mem_data),
        .pop   (pop),
        .head  (buf_head),
        .full  (buf_full),
        .empty (buf_empty)
    );

    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        xfer_count_d = xfer_count_q;
        if (flush) begin
            state_d      = ST_IDLE;
            issue_cnt_d  = '0;
            xfer_count_d = '0;
        end else begin
            if (push && issue_cnt_q != CNT_MAX) begin
                issue_cnt_d = issue_cnt_q + CNT_ONE;
            end
            if (pop && xfer_count_q != CNT_MAX) begin
                xfer_count_d = xfer_count_q + CNT_ONE;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!cfg.is_static && num_lim == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!cfg.is_static && pop && xfer_count_d == num_lim) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            issue_cnt_q  <= '0;
            xfer_count_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            xfer_count_q <= xfer_count_d;
            done_q       <= done_d;
        end
    end

endmodule
